// File: rtl/rt_pkg.sv
// Shared state encoding and LFSR constants for the multi-player reaction timer.
package rt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_GO      = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } rt_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [31:0] SENTINEL_32 = 32'hFFFF_FFFF;

endpackage

// File: rtl/rt_tick_gen.sv
// Millisecond tick prescaler: one-cycle pulse every TICK_DIV clocks, sync clear.
module rt_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic areset_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (clr) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!areset_n) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
endmodule

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction timer: random delay, GO LED, per-player times, winner.
// Define RT_BEST_TRACK_EN to keep the best winning time across rounds.
module reaction_timer_mp
    import rt_pkg::*;
#(
    parameter int N_PLAYERS    = 2,
    parameter int TIME_W       = 14,
    parameter int TICK_DIV     = 100000,
    parameter int DELAY_MIN_MS = 1000,
    parameter int DELAY_MASK   = 1023,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic                          clk,
    input  logic                          areset_n,
    input  logic                          start_btn,
    input  logic [N_PLAYERS-1:0]          player_btn,
    output logic                          led,
    output logic [2:0]                    state,
    output logic [N_PLAYERS*TIME_W-1:0]   reaction,
    output logic [N_PLAYERS-1:0]          false_start,
    output logic [2:0]                    winner,
    output logic                          winner_valid,
    output logic                          done,
    output logic [TIME_W-1:0]             best_time
);
    localparam int DLY_W = 17;
    localparam logic [TIME_W-1:0] T_LIMIT = TIME_W'(TIMEOUT_MS);
    localparam logic [TIME_W-1:0] SENT    = SENTINEL_32[TIME_W-1:0];

    rt_state_e                       state_q, state_d;
    logic [15:0]                     lfsr_q;
    logic                            start_prev_q;
    logic [N_PLAYERS-1:0]            pl_prev_q;
    logic [DLY_W-1:0]                delay_q, delay_d;
    logic [TIME_W-1:0]               elapsed_q, elapsed_d;
    logic [N_PLAYERS-1:0][TIME_W-1:0] react_q, react_d;
    logic [N_PLAYERS-1:0]            fs_q, fs_d, rec_q, rec_d;
    logic [N_PLAYERS-1:0]            new_rec, pl_press;
    logic [2:0]                      win_q, win_d;
    logic                            wv_q, wv_d;
    logic                            start_press, tick, tick_clr;

    rt_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk      (clk),
        .areset_n (areset_n),
        .clr      (tick_clr),
        .tick     (tick)
    );

    assign start_press = start_btn & ~start_prev_q;
    assign pl_press    = player_btn & ~pl_prev_q;

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        elapsed_d = elapsed_q;
        react_d   = react_q;
        fs_d      = fs_q;
        rec_d     = rec_q;
        win_d     = win_q;
        wv_d      = wv_q;
        tick_clr  = 1'b0;
        new_rec   = '0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start_press) begin
                    state_d  = ST_WAIT;
                    delay_d  = DLY_W'(DELAY_MIN_MS)
                             + DLY_W'(lfsr_q & 16'(DELAY_MASK));
                    fs_d     = '0;
                    wv_d     = 1'b0;
                    rec_d    = '0;
                    react_d  = '1;
                    tick_clr = 1'b1;
                end
            end
            ST_WAIT: begin
                fs_d = fs_q | pl_press;
                if (&fs_d) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    if (delay_q <= DLY_W'(1)) begin
                        state_d   = ST_GO;
                        elapsed_d = '0;
                        tick_clr  = 1'b1;
                    end else begin
                        delay_d = delay_q - DLY_W'(1);
                    end
                end
            end
            ST_GO: begin
                new_rec = pl_press & ~fs_q & ~rec_q;
                rec_d   = rec_q | new_rec;
                for (int i = 0; i < N_PLAYERS; i++) begin
                    if (new_rec[i]) react_d[i] = elapsed_q;
                end
                // Descending scan so the lowest index wins a same-cycle tie
                if (!wv_q) begin
                    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
                        if (new_rec[i]) begin
                            win_d = 3'(i);
                            wv_d  = 1'b1;
                        end
                    end
                end
                if (&(rec_d | fs_q)) begin
                    state_d = ST_DONE;
                end else if (tick) begin
                    elapsed_d = elapsed_q + TIME_W'(1);
                    if (elapsed_d == T_LIMIT) state_d = ST_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b1;
            pl_prev_q    <= '1;
            delay_q      <= '0;
            elapsed_q    <= '0;
            react_q      <= '1;
            fs_q         <= '0;
            rec_q        <= '0;
            win_q        <= '0;
            wv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_btn;
            pl_prev_q    <= player_btn;
            delay_q      <= delay_d;
            elapsed_q    <= elapsed_d;
            react_q      <= react_d;
            fs_q         <= fs_d;
            rec_q        <= rec_d;
            win_q        <= win_d;
            wv_q         <= wv_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!areset_n) lfsr_q <= LFSR_SEED;
        else lfsr_q <= {1'b0, lfsr_q[15:1]}
                     ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

`ifdef RT_BEST_TRACK_EN
    logic [TIME_W-1:0] best_q, best_d, win_time;

    always_comb begin
        win_time = SENT;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (win_d == 3'(i)) win_time = react_d[i];
        end
        best_d = best_q;
        if (state_q == ST_GO && state_d == ST_DONE && wv_d
            && win_time < best_q) best_d = win_time;
    end

    always_ff @(posedge clk) begin
        if (!areset_n) best_q <= SENT;
        else           best_q <= best_d;
    end

    assign best_time = best_q;
`else
    assign best_time = SENT;
`endif

    assign state        = state_q;
    assign led          = (state_q == ST_GO);
    assign done         = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
    assign reaction     = react_q;
    assign false_start  = fs_q;
    assign winner       = win_q;
    assign winner_valid = wv_q;
endmodule

// File: doc/reaction_timer_mp.md
Name: reaction_timer_mp

Overview:
- Parametrised multi-player successor to the single-button reaction timer.
- One start button arms a round. A pseudo-random delay elapses, then the LED lights and per-player reaction times are counted in ms ticks.
- Flags false starts (press before LED), picks the winner, applies a round timeout, and optionally tracks the best time across rounds.
- Sits between the debounced/synchronised button inputs and the display/LED logic.

Parameters:
- N_PLAYERS, 2, number of player buttons (1..8)
- TIME_W, 14, width of each reaction/elapsed count (ms)
- TICK_DIV, 100000, clk cycles per ms tick (>=2)
- DELAY_MIN_MS, 1000, fixed part of the pre-LED delay
- DELAY_MASK, 1023, mask applied to the LFSR for the random extra delay
- TIMEOUT_MS, 9999, GO-state limit in ms (< 2^TIME_W - 1)

Ports:
- clk  in  1  system clock
- areset_n  in  1  synchronous active-low reset
- start_btn  in  1  start/re-arm button, synchronous level
- player_btn  in  N_PLAYERS  player buttons, synchronous levels
- led  out  1  go indicator
- state  out  3  current FSM state
- reaction  out  N_PLAYERS*TIME_W  packed per-player times; player i occupies [i*TIME_W +: TIME_W]
- false_start  out  N_PLAYERS  per-player false-start flags
- winner  out  3  index of the winning player
- winner_valid  out  1  winner field is meaningful
- done  out  1  round finished (DONE or TIMEOUT)
- best_time  out  TIME_W  best winning time since reset

Behaviour:
- One clock, one reset: areset_n is synchronous and active-low. All registers are sampled on posedge clk.
- Reset values:
  - state=IDLE, led=0, done=0, winner=0, winner_valid=0, false_start=0
  - every reaction field all-ones, best_time all-ones
  - LFSR=16'hACE1
  - button-history registers all-ones, so a button held through reset gives no edge
- Edge detect: press = level & ~prev. Only rising edges act.
- State encoding: IDLE=0, WAIT=1, GO=2, DONE=3, TIMEOUT=4. Values 5-7 are illegal and go to IDLE on the next clock.
- Tick: prescaler counts 0..TICK_DIV-1; tick=1 for one cycle at TICK_DIV-1. The prescaler clears on entry to WAIT and to GO.
- LFSR: 16-bit Galois, taps 16,14,13,11. Free-runs every clock, including during reset release. Never reaches zero.
- IDLE/DONE/TIMEOUT:
  - led=0. done=1 in DONE and TIMEOUT.
  - A start press goes to WAIT and loads delay = DELAY_MIN_MS + (lfsr & DELAY_MASK).
  - On that transition, clear false_start, winner_valid and done; set reactions to all-ones; clear the recorded mask.
- WAIT:
  - delay decrements on tick. At tick with delay==1: go to GO, led=1 from the next cycle, elapsed=0.
  - A player press sets false_start[i]; that player is disqualified for the round.
  - If all players are disqualified, go to DONE immediately, with winner_valid=0.
- GO:
  - elapsed increments on tick.
  - A press from a non-disqualified, unrecorded player i latches reaction[i]=elapsed (value that cycle) and sets recorded[i].
  - The first recording sets winner and winner_valid. Simultaneous first presses: lowest index wins.
  - Later presses by an already-recorded player are ignored.
  - When every non-disqualified player is recorded: go to DONE, led=0.
  - When elapsed reaches TIMEOUT_MS at tick: go to TIMEOUT, led=0. Unrecorded players keep all-ones.
- start_btn is ignored in WAIT and GO.
- A reset in any state returns to reset values on that clock edge.

Optional Feature:
- Macro: RT_BEST_TRACK_EN.
- Defined: on entry to DONE with winner_valid=1, if the winner's reaction < best_time, then best_time is updated. Persists across rounds and is cleared only by reset.
- Undefined: best_time is tied to all-ones and no comparator is built.

Decomposition:
- Package rt_pkg:
  - state localparams (IDLE..TIMEOUT, width 3)
  - LFSR_SEED=16'hACE1 and the tap mask
  - all-ones sentinel function/constant for TIME_W
- Sub-module rt_tick_gen:
  - parameter TICK_DIV; ports clk, areset_n, clr, tick
  - single-cycle ms tick with synchronous clear

Test Plan (TICK_DIV=4, N_PLAYERS=2, TIMEOUT_MS=50 unless stated):
- Reset: areset_n=0 for 2 clocks -> state=0, led=0, done=0, reaction=all 3FFF, best_time=3FFF, false_start=00.
- Normal round: start press, wait for led=1, p0 press at elapsed 37, p1 at 52 (TIMEOUT_MS=100) -> reaction0=37, reaction1=52, winner=0, winner_valid=1, state=3, done=1, best_time=37 with RT_BEST_TRACK_EN.
- False start: p1 press during WAIT -> false_start=10. After led=1, p0 press at elapsed 20 -> DONE, reaction0=20, reaction1=3FFF, winner=0.
- Tie: both press in the same cycle at elapsed 15 -> reaction0=reaction1=15, winner=0, DONE.
- Timeout: start, no presses -> state=4 after 50 ticks in GO, led=0, winner_valid=0, reactions 3FFF. Then a start press -> state=1, done=0.
- Reset mid-GO: assert areset_n=0 while led=1 -> next edge state=0, led=0, reactions 3FFF; button held through reset gives no false press.
